// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline memory stage: the EX/MEM and
// MEM/WB field positions, the exception codes, the bus FSM states and
// small helpers used by the stage logic.
package mips_pipe_pkg;

    // EX/MEM pipeline register layout (75 bits)
    localparam int EXMEM_W     = 75;
    localparam int EX_REGWRITE = 74;
    localparam int EX_MEMWRITE = 73;
    localparam int EX_MEMTOREG = 72;
    localparam int EX_MEMREAD  = 71;
    localparam int EX_OVF      = 70;
    localparam int EX_ZERO     = 69;
    localparam int EX_RD_HI    = 68;
    localparam int EX_RD_LO    = 64;
    localparam int EX_WDATA_HI = 63;
    localparam int EX_WDATA_LO = 32;
    localparam int EX_ALU_HI   = 31;
    localparam int EX_ALU_LO   = 0;

    // MEM/WB pipeline register layout (38 bits)
    localparam int MEMWB_W     = 38;
    localparam int WB_REGWRITE = 37;
    localparam int WB_RD_HI    = 36;
    localparam int WB_RD_LO    = 32;
    localparam int WB_DATA_HI  = 31;
    localparam int WB_DATA_LO  = 0;

    // A bubble is an all-zero MEM/WB word
    localparam logic [MEMWB_W-1:0] MEMWB_BUBBLE = '0;

    // Exception codes reported alongside the exc pulse
    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_OVERFLOW = 2'b11;

    // Data-bus access state
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bus_state_e;

    // Word accesses require the two low address bits to be zero
    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

    // Assemble a MEM/WB word from its fields
    function automatic logic [MEMWB_W-1:0] pack_memwb(
        input logic        reg_write,
        input logic [4:0]  rd,
        input logic [31:0] data
    );
        return {reg_write, rd, data};
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// External data-memory bus: a variable-latency req/ack handshake.
// The memory stage is the master; the memory (or its model) is the slave.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_bus_fsm.sv
// Bus access sequencer for the memory stage. Tracks whether an access is
// outstanding, counts WAIT cycles for the timeout, and decodes the stall,
// request, completion and timeout conditions.
module mem_bus_fsm
    import mips_pipe_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,      // aligned, non-overflowing access presented in IDLE
    input  logic       ack_i,        // bus completion strobe
    output bus_state_e state_o,
    output logic       stall_o,
    output logic       req_o,
    output logic       ack_done_o,   // access completed this cycle
    output logic       timeout_o     // access abandoned this cycle
);

    localparam int         CNT_W    = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    bus_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_wait;
    logic              at_limit;

    assign in_wait  = (state_q == WAIT);
    assign at_limit = (cnt_q == LAST_CNT);

    // Request is a pure function of the state register, so it drops as soon
    // as reset clears the state.
    assign req_o      = in_wait;
    assign ack_done_o = in_wait && ack_i;
    assign timeout_o  = in_wait && !ack_i && at_limit;
    assign state_o    = state_q;

    // Hold upstream while launching an access or while one is still pending;
    // release on the completing or abandoning cycle and during reset.
    assign stall_o = rst_n && (((state_q == IDLE) && start_i) ||
                               (in_wait && !ack_i && !at_limit));

    // State register and WAIT-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    if (ack_i || at_limit) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the five-stage MIPS pipeline. Issues loads/stores on the
// data bus, selects the MEM/WB word and raises one-cycle exceptions for
// overflow, misalignment and bus timeout.
module memory_stage
    import mips_pipe_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [EXMEM_W-1:0]   EXMEMReg,
    output logic [MEMWB_W-1:0]   MEMWBReg,
    output logic                 stall,
    memory_stage_if.master       bus,
    output logic                 exc,
    output logic [1:0]           exc_code
);

    // EX/MEM field decode
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        overflow;
    logic [4:0]  rd;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic        unused_zero;

    assign reg_write   = EXMEMReg[EX_REGWRITE];
    assign mem_write   = EXMEMReg[EX_MEMWRITE];
    assign mem_to_reg  = EXMEMReg[EX_MEMTOREG];
    assign mem_read    = EXMEMReg[EX_MEMREAD];
    assign overflow    = EXMEMReg[EX_OVF];
    assign rd          = EXMEMReg[EX_RD_HI:EX_RD_LO];
    assign store_data  = EXMEMReg[EX_WDATA_HI:EX_WDATA_LO];
    assign alu_result  = EXMEMReg[EX_ALU_HI:EX_ALU_LO];
    assign unused_zero = EXMEMReg[EX_ZERO];

    logic access;
    logic aligned;
    logic start;

    assign access  = mem_read || mem_write;
    assign aligned = is_word_aligned(alu_result[1:0]);
    assign start   = !overflow && access && aligned;

    bus_state_e state;
    logic       req;
    logic       ack_done;
    logic       timeout;

    mem_bus_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .ack_i      (bus.mem_ack),
        .state_o    (state),
        .stall_o    (stall),
        .req_o      (req),
        .ack_done_o (ack_done),
        .timeout_o  (timeout)
    );

    // Bus outputs come straight from EX/MEM, which upstream holds while stalled.
    // With both MemRead and MemWrite set the access is a store.
    assign bus.mem_req   = req;
    assign bus.mem_we    = mem_write;
    assign bus.mem_addr  = alu_result;
    assign bus.mem_wdata = store_data;

    logic [MEMWB_W-1:0] memwb_q, memwb_d;
    logic               exc_q, exc_d;
    logic [1:0]         exc_code_q, exc_code_d;

    // Next MEM/WB word and exception selection
    always_comb begin
        memwb_d    = MEMWB_BUBBLE;
        exc_d      = 1'b0;
        exc_code_d = EXC_NONE;
        if (state == IDLE) begin
            if (overflow) begin
                exc_d      = 1'b1;
                exc_code_d = EXC_OVERFLOW;
            end else if (access && !aligned) begin
                exc_d      = 1'b1;
                exc_code_d = EXC_MISALIGN;
            end else if (!access) begin
                memwb_d = pack_memwb(reg_write, rd, alu_result);
            end
            // an aligned access launches: bubble while it is outstanding
        end else begin
            if (ack_done) begin
                memwb_d = pack_memwb(reg_write, rd,
                                     mem_to_reg ? bus.mem_rdata : alu_result);
            end else if (timeout) begin
                exc_d      = 1'b1;
                exc_code_d = EXC_TIMEOUT;
            end
            // still waiting: keep a bubble in MEM/WB
        end
    end

    // MEM/WB and exception registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_q    <= MEMWB_BUBBLE;
            exc_q      <= 1'b0;
            exc_code_q <= EXC_NONE;
        end else begin
            memwb_q    <= memwb_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
        end
    end

    assign MEMWBReg = memwb_q;
    assign exc      = exc_q;
    assign exc_code = exc_code_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a driver presents EX/MEM words and
// queues the expected MEM/WB result, a bus responder models the memory,
// and a monitor pops and compares at each retirement.
module tb_memory_stage;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [74:0]  EXMEMReg;
    logic [37:0]  MEMWBReg;
    logic         stall;
    logic         exc;
    logic [1:0]   exc_code;

    memory_stage_if bus();

    memory_stage #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EXMEMReg (EXMEMReg),
        .MEMWBReg (MEMWBReg),
        .stall    (stall),
        .bus      (bus),
        .exc      (exc),
        .exc_code (exc_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [37:0] wb;
        logic        e;
        logic [1:0]  c;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic        inst_valid = 1'b0;
    int          ack_k = 0;
    logic [31:0] rdata_val = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic        exp_we = 1'b0;
    int          req_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [74:0] mk(input logic rw, input logic mw, input logic m2r,
                                       input logic mr, input logic ovf, input logic [4:0] rd,
                                       input logic [31:0] wd, input logic [31:0] alu);
        return {rw, mw, m2r, mr, ovf, 1'b0, rd, wd, alu};
    endfunction

    function automatic exp_t ex(input logic rw, input logic [4:0] rd, input logic [31:0] d,
                                input logic e, input logic [1:0] c);
        exp_t r;
        r.wb = {rw, rd, d};
        r.e  = e;
        r.c  = c;
        return r;
    endfunction

    // Memory model: acks in WAIT cycle ack_k (0 = never) and checks bus fields
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0BAD_F00D;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_req === 1'b1) begin
                wait_cnt++;
                req_cycles++;
                chk("mem_addr", {32'h0, bus.mem_addr}, {32'h0, exp_addr});
                chk("mem_we", {63'h0, bus.mem_we}, {63'h0, exp_we});
                if (exp_we) chk("mem_wdata", {32'h0, bus.mem_wdata}, {32'h0, exp_wdata});
                if (ack_k != 0 && wait_cnt == ack_k) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata_val;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 32'h0BAD_F00D;
                end
            end else begin
                wait_cnt = 0;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'h0BAD_F00D;
            end
        end
    end

    // Monitor: an instruction retires on the edge after a non-stalled cycle
    initial begin
        logic pending;
        exp_t e;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    pending = 1'b0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty actual=retire required=no_retire t=%0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("memwb", {26'h0, MEMWBReg}, {26'h0, e.wb});
                        chk("exc", {63'h0, exc}, {63'h0, e.e});
                        chk("exc_code", {62'h0, exc_code}, {62'h0, e.c});
                        $display("txn retire memwb=%h exc=%b code=%b", MEMWBReg, exc, exc_code);
                    end
                end else begin
                    chk("exc_quiet", {63'h0, exc}, 64'h0);
                end
                if (inst_valid && !stall) pending = 1'b1;
            end
        end
    end

    task automatic run(input string name, input logic [74:0] exm, input int k,
                       input logic [31:0] rdv, input exp_t e,
                       input int exp_stall, input int exp_req);
        int  stall_cycles;
        bit  done;
        @(posedge clk);
        #1;
        EXMEMReg   = exm;
        ack_k      = k;
        rdata_val  = rdv;
        exp_addr   = exm[31:0];
        exp_wdata  = exm[63:32];
        exp_we     = exm[73];
        req_cycles = 0;
        sb.push_back(e);
        inst_valid = 1'b1;
        stall_cycles = 0;
        done = 1'b0;
        @(negedge clk);
        chk("req_low_on_issue", {63'h0, bus.mem_req}, 64'h0);
        for (int i = 0; i < 60 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (stall) stall_cycles++;
            else done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_stall_bound actual=stalled required=release", name);
        end
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
        chk("req_cycles", 64'(req_cycles), 64'(exp_req));
        $display("txn issue %s stall=%0d req=%0d", name, stall_cycles, req_cycles);
    endtask

    task automatic nop();
        @(posedge clk);
        #1;
        EXMEMReg   = '0;
        inst_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        EXMEMReg = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memwb", {26'h0, MEMWBReg}, 64'h0);
        chk("rst_exc", {63'h0, exc}, 64'h0);
        chk("rst_code", {62'h0, exc_code}, 64'h0);
        chk("rst_req", {63'h0, bus.mem_req}, 64'h0);
        rst_n = 1'b1;

        // ALU pass-through
        run("alu", mk(1, 0, 0, 0, 0, 5'd17, 32'h0, 32'd42), 0, 0,
            ex(1, 5'd17, 32'd42, 0, 2'b00), 0, 0);
        // load acked in WAIT cycle 3
        run("load3", mk(1, 0, 1, 1, 0, 5'd5, 32'h0, 32'h64), 3, 32'hDEADBEEF,
            ex(1, 5'd5, 32'hDEADBEEF, 0, 2'b00), 3, 3);
        // store then load back-to-back, both acked in the first WAIT cycle
        run("store", mk(0, 1, 0, 0, 0, 5'd0, 32'd7, 32'h10), 1, 0,
            ex(0, 5'd0, 32'h10, 0, 2'b00), 1, 1);
        run("loadback", mk(1, 0, 1, 1, 0, 5'd8, 32'h0, 32'h10), 1, 32'd7,
            ex(1, 5'd8, 32'd7, 0, 2'b00), 1, 1);
        // misaligned load
        run("misalign", mk(1, 0, 1, 1, 0, 5'd3, 32'h0, 32'h66), 0, 0,
            ex(0, 5'd0, 32'h0, 1, 2'b01), 0, 0);
        // timeout: no ack
        run("timeout", mk(1, 0, 1, 1, 0, 5'd9, 32'h0, 32'h20), 0, 0,
            ex(0, 5'd0, 32'h0, 1, 2'b10), TO, TO);
        // following non-memory instruction completes normally
        run("after_to", mk(1, 0, 0, 0, 0, 5'd4, 32'h0, 32'h1234), 0, 0,
            ex(1, 5'd4, 32'h1234, 0, 2'b00), 0, 0);
        // overflow wins over a store
        run("ovf", mk(1, 1, 0, 0, 1, 5'd6, 32'h55, 32'h40), 1, 0,
            ex(0, 5'd0, 32'h0, 1, 2'b11), 0, 0);
        // ALU result with MemToReg set but no access still passes the ALU value
        run("alu2", mk(1, 0, 1, 0, 0, 5'd31, 32'h0, 32'hFFFF_FFFC), 0, 0,
            ex(1, 5'd31, 32'hFFFF_FFFC, 0, 2'b00), 0, 0);
        nop();

        // reset during WAIT
        @(posedge clk);
        #1;
        EXMEMReg  = mk(1, 0, 1, 1, 0, 5'd2, 32'h0, 32'h30);
        ack_k     = 0;
        exp_addr  = 32'h30;
        exp_we    = 1'b0;
        inst_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("req_before_rst", {63'h0, bus.mem_req}, 64'h1);
        chk("stall_before_rst", {63'h0, stall}, 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_req", {63'h0, bus.mem_req}, 64'h0);
        chk("rst_wait_stall", {63'h0, stall}, 64'h0);
        chk("rst_wait_memwb", {26'h0, MEMWBReg}, 64'h0);
        chk("rst_wait_exc", {63'h0, exc}, 64'h0);
        $display("txn reset_mid_wait req=%b stall=%b", bus.mem_req, stall);
        EXMEMReg = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_memwb", {26'h0, MEMWBReg}, 64'h0);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the five-stage MIPS pipeline. Consumes the 75-bit EX/MEM pipeline register produced by the execution stage, performs loads and stores on an external data-memory bus using a variable-latency req/ack handshake, and registers the 38-bit MEM/WB word that the execution stage's forwarding unit and the write-back stage read. It stalls upstream while a bus access is outstanding and reports overflow, misalignment and bus-timeout exceptions.

## Interface
- TIMEOUT, 15: WAIT-state cycles without `mem_ack` before the access is abandoned (legal range 1-255).
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EXMEMReg  in  75  [74] RegWrite, [73] MemWrite, [72] MemToReg, [71] MemRead, [70] overflow, [69] zero (unused), [68:64] write register, [63:32] store data, [31:0] ALU result / byte address.
- MEMWBReg  out  38  registered: [37] RegWrite, [36:32] write register, [31:0] result.
- stall  out  1  combinational; while high, upstream holds EXMEMReg unchanged.
- mem_req  out  1  bus request; high only in WAIT.
- mem_we  out  1  1 = store; valid while mem_req.
- mem_addr  out  32  EXMEMReg[31:0]; valid while mem_req.
- mem_wdata  out  32  EXMEMReg[63:32]; valid while mem_req.
- mem_rdata  in  32  load data; sampled on the edge where mem_ack is high.
- mem_ack  in  1  one-cycle completion strobe; ignored outside WAIT.
- exc  out  1  registered one-cycle exception pulse.
- exc_code  out  2  valid with exc: 01 misaligned, 10 bus timeout, 11 arithmetic overflow.

## Operation
- access = MemRead | MemWrite. If both are set, the instruction is treated as a store; RegWrite passes through unchanged.
- Bubble = MEMWBReg all zeros.
- States: IDLE, WAIT.
- In IDLE, priority order:
  - overflow=1: no access, bubble, exc with code 11, stall=0.
  - access with ALU result [1:0] != 0: no access, bubble, exc with code 01, stall=0.
  - access: stall=1; next state WAIT; MEMWBReg <= bubble; cycle counter cleared.
  - otherwise: MEMWBReg <= {RegWrite, write register, ALU result}.
- In WAIT, mem_req=1 and mem_we=MemWrite.
  - mem_ack=1: stall=0 this cycle. MEMWBReg <= {RegWrite, write register, MemToReg ? mem_rdata : ALU result}. Next state IDLE.
  - No ack, counter == TIMEOUT-1: stall=0, mem_req still high this cycle. Next state IDLE, bubble, exc with code 10.
  - Otherwise: stall=1, counter increments.
- A store with RegWrite=0 writes back as RegWrite=0; the result field holds the ALU result.

## Timing
- Reset (async, immediate): state IDLE, counter 0, MEMWBReg 0, exc 0, exc_code 00. mem_req falls combinationally. A reset during WAIT abandons the access; no exception is raised.
- Non-memory instruction: MEMWBReg valid 1 edge after it is presented.
- Memory access with ack in WAIT cycle k (k >= 1): MEMWBReg valid after k+1 edges. stall is high for k cycles.
- Back-to-back accesses: the next access enters WAIT one cycle after the previous ack. There are no concurrent requests.
- mem_addr, mem_wdata and mem_we are stable for the whole of mem_req, because stall holds EXMEMReg.
- exc is high exactly one cycle, coincident with the bubble appearing in MEMWBReg.

## Structure
- Shared package mips_pipe_pkg:
  - EXMEMReg and MEMWBReg field-index localparams.
  - Exception-code constants.
  - State enum {IDLE, WAIT}.
- One sub-module, mem_bus_fsm: state register, timeout counter, and the stall / mem_req / ack decode.
- memory_stage keeps only the MEMWBReg mux/register and the exception register.

## Test plan
- ALU pass-through: RegWrite=1, rd=17, ALU result=42, no access → MEMWBReg = {1, 17, 42} after 1 edge; stall never high.
- Load, ack after 3 WAIT cycles: MemRead=1, MemToReg=1, address 0x64, mem_rdata=0xDEADBEEF.
  - stall high 3 cycles; mem_addr=0x64, mem_we=0.
  - MEMWBReg = {1, rd, 0xDEADBEEF}.
- Store then load back-to-back: store data 7 to address 0x10, then load from 0x10 with ack in the first WAIT cycle.
  - Two request windows with mem_req low between them; mem_we=1 then 0.
  - Store write-back has RegWrite=0.
- Misaligned access: MemRead=1, address 0x66 → no mem_req, bubble, exc=1 with code 01 for one cycle.
- Timeout with TIMEOUT=4 and no ack:
  - mem_req high 4 cycles, then exc with code 10 and a bubble.
  - The following non-memory instruction completes normally.
- Overflow and reset:
  - overflow=1 with MemWrite=1 → no request, exc with code 11.
  - rst_n asserted mid-WAIT → mem_req, stall and MEMWBReg go to 0 immediately; no exc.
